pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage scalar/vector pipeline (F/D/E/M/W).
- Drives the enable and flush inputs of every inter-stage pipe register.
- Generates E-stage forwarding selects for scalar and vector operands.
- Sequences multi-cycle data-memory stalls with a timeout FSM, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/fwd_unit.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: memory-stall FSM states
// and E-stage forwarding select encodings.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } fsm_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one E-stage source operand; M beats W, and a load
// still in M cannot forward because its data is not back yet.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             write_m,
    input  logic [IDX_W-1:0] idx_m,
    input  logic             memtoreg_m,
    input  logic             write_w,
    input  logic [IDX_W-1:0] idx_w,
    input  logic [IDX_W-1:0] src,
    output fwd_sel_t         sel
);

    always_comb begin
        sel = FWD_RF;
        if (write_m && !memtoreg_m && (idx_m == src))
            sel = FWD_M;
        else if (write_w && (idx_w == src))
            sel = FWD_W;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the F/D/E/M/W pipeline: pipe register enables
// and flushes, operand forwarding, data-memory stall timeout and stall counter.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16,
    parameter int SREG_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrc_W,
    input  logic              mem_req_M,
    input  logic              mem_ready,
    input  logic              MemtoReg_E,
    input  logic              ScalarWrite_E,
    input  logic              VectorWrite_E,
    input  logic [SREG_W-1:0] RnD_E,
    input  logic              RvD_E,
    input  logic [SREG_W-1:0] RnA_D,
    input  logic [SREG_W-1:0] RnB_D,
    input  logic              RvA_D,
    input  logic              RvB_D,
    input  logic              UseA_D,
    input  logic              UseB_D,
    input  logic              UseVA_D,
    input  logic              UseVB_D,
    input  logic [SREG_W-1:0] RnA_E,
    input  logic [SREG_W-1:0] RnB_E,
    input  logic              RvA_E,
    input  logic              RvB_E,
    input  logic              ScalarWrite_M,
    input  logic              VectorWrite_M,
    input  logic              MemtoReg_M,
    input  logic [SREG_W-1:0] RnD_M,
    input  logic              RvD_M,
    input  logic              ScalarWrite_W,
    input  logic              VectorWrite_W,
    input  logic [SREG_W-1:0] RnD_W,
    input  logic              RvD_W,
    output logic              enable_F,
    output logic              enable_D,
    output logic              enable_E,
    output logic              enable_M,
    output logic              enable_W,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic              flush_W,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [1:0]        ForwardVAE,
    output logic [1:0]        ForwardVBE,
    output logic              mem_error,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TIMEOUT = TCNT_W'(MEM_TIMEOUT);

    fsm_state_t        state, state_next;
    logic [TCNT_W-1:0] tcount, tcount_next, tcount_inc;
    logic              mem_stall, load_use;
    fwd_sel_t          fwd_a, fwd_b, fwd_va, fwd_vb;

    assign tcount_inc = tcount + 1'b1;

    // The counter holds the number of stalled cycles so far; reaching the
    // timeout moves to ERROR, which releases the stall instead of stalling again.
    always_comb begin
        state_next  = state;
        tcount_next = tcount;
        mem_stall   = 1'b0;
        case (state)
            IDLE: begin
                if (!PCSrc_W && mem_req_M && !mem_ready) begin
                    mem_stall   = 1'b1;
                    tcount_next = TCNT_W'(1);
                    state_next  = (TCNT_W'(1) >= TIMEOUT) ? ERROR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (PCSrc_W || mem_ready) begin
                    state_next  = IDLE;
                    tcount_next = '0;
                end else begin
                    mem_stall   = 1'b1;
                    tcount_next = tcount_inc;
                    if (tcount_inc >= TIMEOUT)
                        state_next = ERROR;
                end
            end
            ERROR: begin
                tcount_next = '0;
            end
            default: begin
                state_next  = IDLE;
                tcount_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tcount    <= '0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_next;
            tcount    <= (state_next == ERROR) ? '0 : tcount_next;
            mem_error <= mem_error || (state_next == ERROR);
        end
    end

    assign load_use = MemtoReg_E &&
        ((ScalarWrite_E && ((UseA_D && (RnD_E == RnA_D)) || (UseB_D && (RnD_E == RnB_D)))) ||
         (VectorWrite_E && ((UseVA_D && (RvD_E == RvA_D)) || (UseVB_D && (RvD_E == RvB_D)))));

    // Branch beats memory stall beats load-use; reset forces the quiet pattern.
    always_comb begin
        {enable_F, enable_D, enable_E, enable_M, enable_W} = 5'b11111;
        {flush_D, flush_E, flush_M, flush_W}               = 4'b0000;
        if (!reset) begin
            if (PCSrc_W) begin
                {flush_D, flush_E, flush_M} = 3'b111;
            end else if (mem_stall) begin
                {enable_F, enable_D, enable_E, enable_M} = 4'b0000;
                flush_W = 1'b1;
            end else if (load_use) begin
                {enable_F, enable_D} = 2'b00;
                flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (!enable_F && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

    fwd_unit #(.IDX_W(SREG_W)) u_fwd_a (
        .write_m(ScalarWrite_M), .idx_m(RnD_M), .memtoreg_m(MemtoReg_M),
        .write_w(ScalarWrite_W), .idx_w(RnD_W), .src(RnA_E), .sel(fwd_a));
    fwd_unit #(.IDX_W(SREG_W)) u_fwd_b (
        .write_m(ScalarWrite_M), .idx_m(RnD_M), .memtoreg_m(MemtoReg_M),
        .write_w(ScalarWrite_W), .idx_w(RnD_W), .src(RnB_E), .sel(fwd_b));
    fwd_unit #(.IDX_W(1)) u_fwd_va (
        .write_m(VectorWrite_M), .idx_m(RvD_M), .memtoreg_m(MemtoReg_M),
        .write_w(VectorWrite_W), .idx_w(RvD_W), .src(RvA_E), .sel(fwd_va));
    fwd_unit #(.IDX_W(1)) u_fwd_vb (
        .write_m(VectorWrite_M), .idx_m(RvD_M), .memtoreg_m(MemtoReg_M),
        .write_w(VectorWrite_W), .idx_w(RvD_W), .src(RvB_E), .sel(fwd_vb));

    assign ForwardAE  = reset ? FWD_RF : fwd_a;
    assign ForwardBE  = reset ? FWD_RF : fwd_b;
    assign ForwardVAE = reset ? FWD_RF : fwd_va;
    assign ForwardVBE = reset ? FWD_RF : fwd_vb;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed scoreboard bench for pipeline_hazard_ctrl, built with
// MEM_TIMEOUT=4 and CNT_W=4 so timeout and counter saturation are reachable.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int SREG_W      = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       pcsrc, mem_req, mem_ready;
        logic       memtoreg_e, swrite_e, vwrite_e;
        logic [2:0] rnd_e;
        logic       rvd_e;
        logic [2:0] rna_d, rnb_d;
        logic       rva_d, rvb_d, usea, useb, useva, usevb;
        logic [2:0] rna_e, rnb_e;
        logic       rva_e, rvb_e;
        logic       swrite_m, vwrite_m, memtoreg_m;
        logic [2:0] rnd_m;
        logic       rvd_m;
        logic       swrite_w, vwrite_w;
        logic [2:0] rnd_w;
        logic       rvd_w;
    } stim_t;

    typedef struct packed {
        logic [4:0]       en;
        logic [3:0]       fl;
        logic [7:0]       fwd;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic PCSrc_W, mem_req_M, mem_ready, MemtoReg_E, ScalarWrite_E, VectorWrite_E;
    logic [SREG_W-1:0] RnD_E, RnA_D, RnB_D, RnA_E, RnB_E, RnD_M, RnD_W;
    logic RvD_E, RvA_D, RvB_D, UseA_D, UseB_D, UseVA_D, UseVB_D, RvA_E, RvB_E;
    logic ScalarWrite_M, VectorWrite_M, MemtoReg_M, RvD_M, ScalarWrite_W, VectorWrite_W, RvD_W;
    logic enable_F, enable_D, enable_E, enable_M, enable_W;
    logic flush_D, flush_E, flush_M, flush_W;
    logic [1:0] ForwardAE, ForwardBE, ForwardVAE, ForwardVBE;
    logic mem_error;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int passes = 0;
    exp_t expq[$];

    // Reference model state: memory phase, stalled cycles of the current access,
    // sticky error and the stall counter.
    typedef enum int {PH_IDLE, PH_WAIT, PH_ERR} phase_t;
    phase_t m_phase = PH_IDLE;
    int m_waited = 0;
    bit m_err = 1'b0;
    int m_stalls = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W), .SREG_W(SREG_W)) dut (
        .clk(clk), .reset(reset), .PCSrc_W(PCSrc_W), .mem_req_M(mem_req_M), .mem_ready(mem_ready),
        .MemtoReg_E(MemtoReg_E), .ScalarWrite_E(ScalarWrite_E), .VectorWrite_E(VectorWrite_E),
        .RnD_E(RnD_E), .RvD_E(RvD_E), .RnA_D(RnA_D), .RnB_D(RnB_D), .RvA_D(RvA_D), .RvB_D(RvB_D),
        .UseA_D(UseA_D), .UseB_D(UseB_D), .UseVA_D(UseVA_D), .UseVB_D(UseVB_D),
        .RnA_E(RnA_E), .RnB_E(RnB_E), .RvA_E(RvA_E), .RvB_E(RvB_E),
        .ScalarWrite_M(ScalarWrite_M), .VectorWrite_M(VectorWrite_M), .MemtoReg_M(MemtoReg_M),
        .RnD_M(RnD_M), .RvD_M(RvD_M), .ScalarWrite_W(ScalarWrite_W), .VectorWrite_W(VectorWrite_W),
        .RnD_W(RnD_W), .RvD_W(RvD_W),
        .enable_F(enable_F), .enable_D(enable_D), .enable_E(enable_E), .enable_M(enable_M),
        .enable_W(enable_W), .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
        .flush_W(flush_W), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardVAE(ForwardVAE),
        .ForwardVBE(ForwardVBE), .mem_error(mem_error), .stall_cycles(stall_cycles));

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_fwd(logic wm, logic [2:0] im, logic mtr,
                                           logic ww, logic [2:0] iw, logic [2:0] src);
        if (wm && im == src && !mtr) return 2'b10;
        if (ww && iw == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.en = 5'b11111; e.fl = 4'b0000; e.fwd = 8'h00; e.err = 1'b0; e.cnt = '0;
        return e;
    endfunction

    function automatic bit mem_stalls(stim_t s);
        if (s.pcsrc) return 1'b0;
        if (m_phase == PH_IDLE) return s.mem_req && !s.mem_ready;
        if (m_phase == PH_WAIT) return !s.mem_ready;
        return 1'b0;
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t e;
        bit lu;
        lu = s.memtoreg_e &&
             ((s.swrite_e && ((s.usea && s.rnd_e == s.rna_d) || (s.useb && s.rnd_e == s.rnb_d))) ||
              (s.vwrite_e && ((s.useva && s.rvd_e == s.rva_d) || (s.usevb && s.rvd_e == s.rvb_d))));
        e = reset_exp();
        if (s.pcsrc) e.fl = 4'b1110;
        else if (mem_stalls(s)) begin e.en = 5'b00001; e.fl = 4'b0001; end
        else if (lu) begin e.en = 5'b00111; e.fl = 4'b0100; end
        e.fwd = {exp_fwd(s.swrite_m, s.rnd_m, s.memtoreg_m, s.swrite_w, s.rnd_w, s.rna_e),
                 exp_fwd(s.swrite_m, s.rnd_m, s.memtoreg_m, s.swrite_w, s.rnd_w, s.rnb_e),
                 exp_fwd(s.vwrite_m, {2'b00, s.rvd_m}, s.memtoreg_m, s.vwrite_w, {2'b00, s.rvd_w}, {2'b00, s.rva_e}),
                 exp_fwd(s.vwrite_m, {2'b00, s.rvd_m}, s.memtoreg_m, s.vwrite_w, {2'b00, s.rvd_w}, {2'b00, s.rvb_e})};
        e.err = m_err;
        e.cnt = CNT_W'(m_stalls);
        return e;
    endfunction

    // Advance the model across the clock edge that ends the current cycle.
    function automatic void model_step(stim_t s, exp_t e);
        bit stalled = mem_stalls(s);
        if (stalled) begin
            m_waited = m_waited + 1;
            if (m_waited >= MEM_TIMEOUT) begin m_phase = PH_ERR; m_err = 1'b1; m_waited = 0; end
            else m_phase = PH_WAIT;
        end else if (m_phase == PH_WAIT) begin
            m_phase = PH_IDLE; m_waited = 0;
        end
        if (!e.en[4] && m_stalls < CNT_MAX) m_stalls = m_stalls + 1;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    endtask

    task automatic checkOutput(exp_t e);
        check("enables", 16'({enable_F, enable_D, enable_E, enable_M, enable_W}), 16'(e.en));
        check("flushes", 16'({flush_D, flush_E, flush_M, flush_W}), 16'(e.fl));
        check("forwards", 16'({ForwardAE, ForwardBE, ForwardVAE, ForwardVBE}), 16'(e.fwd));
        check("mem_error", 16'(mem_error), 16'(e.err));
        check("stall_cycles", 16'(stall_cycles), 16'(e.cnt));
    endtask

    task automatic drive(stim_t s);
        PCSrc_W = s.pcsrc; mem_req_M = s.mem_req; mem_ready = s.mem_ready;
        MemtoReg_E = s.memtoreg_e; ScalarWrite_E = s.swrite_e; VectorWrite_E = s.vwrite_e;
        RnD_E = s.rnd_e; RvD_E = s.rvd_e; RnA_D = s.rna_d; RnB_D = s.rnb_d;
        RvA_D = s.rva_d; RvB_D = s.rvb_d; UseA_D = s.usea; UseB_D = s.useb;
        UseVA_D = s.useva; UseVB_D = s.usevb; RnA_E = s.rna_e; RnB_E = s.rnb_e;
        RvA_E = s.rva_e; RvB_E = s.rvb_e; ScalarWrite_M = s.swrite_m; VectorWrite_M = s.vwrite_m;
        MemtoReg_M = s.memtoreg_m; RnD_M = s.rnd_m; RvD_M = s.rvd_m;
        ScalarWrite_W = s.swrite_w; VectorWrite_W = s.vwrite_w; RnD_W = s.rnd_w; RvD_W = s.rvd_w;
    endtask

    task automatic applyStimulus(stim_t s, bit rst);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        drive(s);
        if (rst) begin
            m_phase = PH_IDLE; m_waited = 0; m_err = 1'b0; m_stalls = 0;
            e = reset_exp();
        end else begin
            e = predict(s);
            model_step(s, e);
        end
        expq.push_back(e);
    endtask

    function automatic logic [2:0] rand_idx();
        return ($urandom_range(0, 1) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = stim_t'({$urandom, $urandom});
        s.pcsrc = ($urandom_range(0, 9) == 0);
        s.mem_req = ($urandom_range(0, 2) == 0);
        s.memtoreg_e = ($urandom_range(0, 1) == 0);
        s.rnd_e = rand_idx(); s.rna_d = rand_idx(); s.rnb_d = rand_idx();
        s.rna_e = rand_idx(); s.rnb_e = rand_idx(); s.rnd_m = rand_idx(); s.rnd_w = rand_idx();
        return s;
    endfunction

    // Monitor: every cycle that has a pending expectation is checked mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) checkOutput(expq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t z, s;
        z = '0;
        applyStimulus(z, 1'b1);
        applyStimulus(z, 1'b1);

        // Load-use on R3, then the consumer in E picks R3 up from W.
        s = z; s.memtoreg_e = 1; s.swrite_e = 1; s.rnd_e = 3; s.rna_d = 3; s.usea = 1;
        applyStimulus(s, 1'b0);
        applyStimulus(z, 1'b0);
        s = z; s.rna_e = 3; s.swrite_w = 1; s.rnd_w = 3;
        applyStimulus(s, 1'b0);

        // M beats W, but a load in M defers to W; index 0 forwards too.
        s = z; s.swrite_m = 1; s.rnd_m = 5; s.swrite_w = 1; s.rnd_w = 5; s.rna_e = 5;
        applyStimulus(s, 1'b0);
        s.memtoreg_m = 1;
        applyStimulus(s, 1'b0);
        s = z; s.vwrite_m = 1; s.vwrite_w = 1; s.rvd_w = 1; s.rvb_e = 1; s.swrite_w = 1; s.rnb_e = 0;
        applyStimulus(s, 1'b0);

        // Three-cycle memory stall then release.
        s = z; s.mem_req = 1;
        for (int i = 0; i < 3; i++) applyStimulus(s, 1'b0);
        s.mem_ready = 1;
        applyStimulus(s, 1'b0);
        applyStimulus(z, 1'b0);

        // Branch abandons a pending access; a late mem_ready does nothing.
        s = z; s.mem_req = 1;
        applyStimulus(s, 1'b0);
        applyStimulus(s, 1'b0);
        s.pcsrc = 1;
        applyStimulus(s, 1'b0);
        s = z; s.mem_ready = 1;
        applyStimulus(s, 1'b0);

        // Timeout into ERROR; afterwards no memory stalls, load-use still works.
        s = z; s.mem_req = 1;
        for (int i = 0; i < 7; i++) applyStimulus(s, 1'b0);
        s.memtoreg_e = 1; s.vwrite_e = 1; s.rvd_e = 1; s.rvb_d = 1; s.usevb = 1;
        applyStimulus(s, 1'b0);
        s.pcsrc = 1;
        applyStimulus(s, 1'b0);

        // Randomised segments, each starting from reset.
        for (int seg = 0; seg < 4; seg++) begin
            applyStimulus(z, 1'b1);
            for (int i = 0; i < 60; i++) applyStimulus(rand_stim(), 1'b0);
        end

        // Counter saturation through a long run of load-use stalls.
        applyStimulus(z, 1'b1);
        s = z; s.memtoreg_e = 1; s.swrite_e = 1; s.rnd_e = 6; s.rnb_d = 6; s.useb = 1;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) applyStimulus(s, 1'b0);

        // Asynchronous reset in the middle of a memory stall.
        s = z; s.mem_req = 1; s.swrite_m = 1; s.rnd_m = 5; s.rna_e = 5;
        applyStimulus(s, 1'b0);
        applyStimulus(s, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_enables", 16'({enable_F, enable_D, enable_E, enable_M, enable_W}), 16'h001f);
        check("async_flushes", 16'({flush_D, flush_E, flush_M, flush_W}), 16'h0000);
        check("async_forwards", 16'({ForwardAE, ForwardBE, ForwardVAE, ForwardVBE}), 16'h0000);
        check("async_stall_cycles", 16'(stall_cycles), 16'h0000);
        check("queue_drain", 16'(expq.size()), 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
